max_52_2_frame_reduce: RTL and testbench
========================================

// Module: max_52_2_frame_reduce
// PURPOSE
//  Downstream consumer of the approximate max_52_2 datapath.
//  Takes the 5-bit result word {po4..po0} once per accepted beat over a valid/ready stream.
//  Reduces each frame of samples to its maximum value, the index of its first occurrence,
//  and the sample count.
//  Presents the frame summary on a held output handshake for the error-monitoring and logging stage.
// PARAMETERS
//  FRAME_LEN  16  samples per frame; 1 <= FRAME_LEN <= 2**IDX_W
//  IDX_W      4   width of the sample index inside a frame
// PORTS
//  clk        in   1        single clock; all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        upstream word valid
//  in_ready   out  1        block can accept a word
//  in_data    in   5        {po4,po3,po2,po1,po0} from max_52_2, unsigned
//  in_last    in   1        early frame terminator; sampled only on an accepted beat
//  out_valid  out  1        frame summary valid
//  out_ready  in   1        downstream accepts summary
//  out_max    out  5        maximum in_data over the frame
//  out_idx    out  IDX_W    index (0-based) of first sample equal to out_max
//  out_len    out  IDX_W+1  number of samples in the frame (1..FRAME_LEN)
// BEHAVIOUR
//  Reset and interface
//  - One clock; reset asynchronous active-high.
//    rst forces state=IDLE and cnt/max/idx=0, so out_valid=0, out_max=0, out_idx=0 and out_len=0.
//    in_ready reads 1 whenever rst is low and state!=HOLD.
//  - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
//    Cycles without an accept change no state.
//  - in_ready = (state != HOLD). No pass-through: while in HOLD, in_ready=0 even if out_ready=1.
//    This costs one bubble per frame.
//  State machine (IDLE, ACCUM, HOLD)
//  - IDLE: on accept: max<=in_data, idx<=0, cnt<=1.
//    Go to HOLD if FRAME_LEN==1 or in_last; otherwise go to ACCUM.
//  - ACCUM: on accept: if in_data > max (strict), then max<=in_data and idx<=cnt.
//    Ties keep the earlier index. cnt<=cnt+1.
//    Go to HOLD when cnt==FRAME_LEN-1 (the final beat) or when in_last=1.
//  - HOLD: out_valid=1; out_max, out_idx and out_len(=cnt) are registered and stable until emit.
//    On emit, go to IDLE and clear out_valid on the same edge.
//  Timing and arithmetic
//  - Latency: out_valid rises on the clock edge that accepts the frame's final beat.
//    It is visible the cycle after that beat.
//  - Comparison is 5-bit unsigned; no saturation is needed.
//    cnt is IDX_W+1 bits and never exceeds FRAME_LEN.
//  - in_last on the FRAME_LEN-th beat is redundant; it closes exactly one frame.
//  - in_data and in_last are don't-care when in_valid=0 or in_ready=0.
//  - Reset asserted mid-frame or during HOLD discards the partial frame or summary.
//    The first accept after release starts a new frame at index 0.
//  - out_valid never drops without an emit, except on rst.
// TESTING
//  1. FRAME_LEN=16; stream 3,7,7,2, then twelve 1s, no bubbles
//     -> one summary: out_max=7, out_idx=1, out_len=16; in_ready=0 for exactly one cycle.
//  2. Stream 5,31,0 with in_last on the third beat
//     -> out_max=31, out_idx=1, out_len=3; the next word starts a new frame at index 0.
//  3. Hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 throughout
//     -> outputs stable, in_ready=0, no word consumed; summary emitted on the first out_ready=1.
//  4. in_valid toggling 1,0,0,1,... across a 16-sample frame
//     -> bubbles do not advance cnt; out_len=16 after 16 accepts only.
//  5. Assert rst after 9 accepted words (max=20), then send a 16-word all-zero frame
//     -> outputs 0 during rst; summary out_max=0, out_idx=0, out_len=16 with no trace of 20.
//  6. FRAME_LEN=1; words 4,9 back-to-back with out_ready=1
//     -> two summaries (4,0,1) and (9,0,1), each one cycle after its accept.

Source files
------------

// File: rtl/max_52_2_frame_reduce.sv
// max_52_2_frame_reduce: reduces each stream frame to its max, first index of max and length.
// The summary is held on a valid/ready output until it is taken; no input is accepted meanwhile.
module max_52_2_frame_reduce #(
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_len
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           state_q, state_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [4:0]       max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept, emit, close;
    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;
    // A frame closes on in_last or on its FRAME_LEN-th accepted beat.
    assign close  = in_last | ((state_q == IDLE) ? (FRAME_LEN == 1)
                                                 : (cnt_q == (IDX_W+1)'(FRAME_LEN - 1)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (accept) state_d = close ? HOLD : ACCUM;
            HOLD:        if (emit) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end
    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
        idx_d = idx_q;
        if (accept && state_q == IDLE) begin
            cnt_d = (IDX_W+1)'(1);
            max_d = in_data;
            idx_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            max_d = (in_data > max_q) ? in_data : max_q;
            idx_d = (in_data > max_q) ? cnt_q[IDX_W-1:0] : idx_q;
        end
    end
    always_comb begin
        in_ready  = !rst && state_q != HOLD;
        out_valid = state_q == HOLD;
        out_max   = max_q;
        out_idx   = idx_q;
        out_len   = cnt_q;
    end
endmodule

// File: tb/tb_max_52_2_frame_reduce.sv
// tb_max_52_2_frame_reduce: drives a FRAME_LEN=16 and a FRAME_LEN=1 instance from shared inputs
// and compares both against a frame-buffer reference model.
module tb_max_52_2_frame_reduce;
    logic       clk, rst, in_valid, in_last, out_ready;
    logic [4:0] in_data;
    logic       ir [2];
    logic       ov [2];
    logic [4:0] omax [2];
    logic [3:0] oidx [2];
    logic [4:0] olen [2];

    max_52_2_frame_reduce #(.FRAME_LEN(16), .IDX_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_max(omax[0]),
        .out_idx(oidx[0]), .out_len(olen[0]));
    max_52_2_frame_reduce #(.FRAME_LEN(1), .IDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_max(omax[1]),
        .out_idx(oidx[1]), .out_len(olen[1]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int         n_asrt = 0, n_fail = 0;
    int         fl [2] = '{16, 1};
    bit         hold [2];
    int         fcnt [2];
    logic [4:0] fbuf [2][16];
    logic [4:0] emax [2];
    int         eidx [2], elen [2];

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] got=%0d exp=%0d", tag, k, got, exp);
        end
    endtask

    // Frame summary from the buffered samples: the max value, then the first position holding it.
    task automatic close_frame(input int k);
        emax[k] = 0;
        for (int i = 0; i < fcnt[k]; i++) if (fbuf[k][i] > emax[k]) emax[k] = fbuf[k][i];
        eidx[k] = -1;
        for (int i = 0; i < fcnt[k]; i++) if (eidx[k] < 0 && fbuf[k][i] == emax[k]) eidx[k] = i;
        elen[k] = fcnt[k];
        fcnt[k] = 0;
        hold[k] = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, ov[k], 0);
            chk("rst_out_max", k, omax[k], 0);
            chk("rst_out_idx", k, oidx[k], 0);
            chk("rst_out_len", k, olen[k], 0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            hold[k] = 0;
            fcnt[k] = 0;
        end
    endtask

    task automatic cyc(input bit v, input logic [4:0] d, input bit l, input bit r);
        bit acc [2];
        bit em [2];
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("in_ready", k, ir[k], !hold[k]);
            chk("out_valid", k, ov[k], hold[k]);
            if (hold[k]) begin
                chk("out_max", k, omax[k], emax[k]);
                chk("out_idx", k, oidx[k], eidx[k]);
                chk("out_len", k, olen[k], elen[k]);
            end
            acc[k] = v && !hold[k];
            em[k]  = hold[k] && r;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if (em[k]) hold[k] = 0;
            else if (acc[k]) begin
                fbuf[k][fcnt[k]] = d;
                fcnt[k]++;
                if (fcnt[k] == fl[k] || l) close_frame(k);
            end
        end
    endtask

    logic [4:0] t1 [16] = '{3, 7, 7, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        rst = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        @(posedge clk); #1;
        do_reset();
        // 1: full frame without bubbles, ties keep the earlier index
        for (int i = 0; i < 16; i++) cyc(1, t1[i], 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // 2: early termination, then a fresh frame from index 0
        cyc(1, 5, 0, 1); cyc(1, 31, 0, 1); cyc(1, 0, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 6, 0, 1); cyc(1, 2, 1, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // 3: back-pressure on the summary with input pending
        for (int i = 0; i < 16; i++) cyc(1, 5'($urandom_range(0, 31)), 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 5'd30, 0, 0);
        cyc(1, 5'd30, 0, 1);
        cyc(1, 5'd30, 1, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // 4: bubbles do not advance the count
        for (int i = 0; i < 48; i++) cyc(i % 3 == 0, 5'($urandom_range(0, 31)), 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // 5: reset mid-frame discards the partial frame
        for (int i = 0; i < 9; i++) cyc(1, (i == 4) ? 5'd20 : 5'd3, 0, 1);
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // 6: back-to-back single-sample frames on the FRAME_LEN=1 instance
        cyc(1, 4, 0, 1); cyc(1, 9, 0, 1); cyc(1, 9, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        // Random traffic with ties, early ends, back-pressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
